ccr_shadow_stack: RTL
=====================

Name: ccr_shadow_stack

Overview:
- Hardware LIFO that saves the condition-code flags {V,C,N,Z} on interrupt entry and restores them on RTI.
- Sits directly upstream of the condition code register. It drives that register's load_from_stack strobe and its stack_flags_in bus, and it samples the register's ccr_out.
- Supports nested interrupts up to DEPTH levels and reports overflow/underflow errors to the interrupt controller.

Parameters:
- DEPTH, 4, number of saved flag entries (nesting levels); must be a power of two, at least 2.
- FLAG_W, 4, flag vector width, ordered {V,C,N,Z}.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ccr_in  in  FLAG_W  current flags from the condition code register's ccr_out.
- int_ack  in  1  interrupt accepted this cycle; push ccr_in.
- rti_exec  in  1  RTI in execute this cycle; pop.
- err_clr  in  1  clears sticky error flags.
- load_from_stack  out  1  one-cycle restore strobe to the condition code register.
- stack_flags_out  out  FLAG_W  restored flags; valid while load_from_stack is high.
- depth  out  $clog2(DEPTH)+1  number of valid entries.
- full  out  1  depth == DEPTH.
- empty  out  1  depth == 0.
- overflow_err  out  1  sticky; a push was attempted while full.
- underflow_err  out  1  sticky; a pop was attempted while empty.

Behaviour:
- Reset (asynchronous): depth=0, empty=1, full=0, load_from_stack=0, stack_flags_out=0, both error flags=0, FSM=IDLE. Storage contents are don't-care. Reset asserted mid-restore cancels the pending strobe immediately.
- Storage: DEPTH x FLAG_W register array, top-of-stack pointer = depth-1. full and empty are combinational from depth.
- FSM states:
  - IDLE: no restore pending.
  - RESTORE: entered for exactly one cycle after an accepted pop; load_from_stack=1. Returns to IDLE unconditionally on the next edge.
- Push (int_ack=1, rti_exec=0, not full): at the edge, entry[depth] <= ccr_in and depth += 1. No output strobe.
- Push when full: stack and depth unchanged; overflow_err <= 1.
- Pop (rti_exec=1, int_ack=0, not empty): at edge N, stack_flags_out <= entry[depth-1], depth -= 1, FSM -> RESTORE. load_from_stack is high for cycle N+1 only, so latency is one cycle from rti_exec to strobe.
- Pop when empty: no strobe; stack_flags_out holds its value; underflow_err <= 1.
- Simultaneous int_ack and rti_exec (tail-chain):
  - Stack contents and depth are unchanged; no load_from_stack strobe.
  - The interrupted context's flags remain saved for the next handler.
  - If empty, underflow_err is set; the push is not performed.
- Back-to-back pops on consecutive cycles are legal. Each produces its own one-cycle strobe, so load_from_stack stays high across them with the successive values.
- A push in the cycle the strobe is high samples ccr_in as presented. The upstream pipeline guarantees ccr_in already reflects the restore, or stalls.
- err_clr=1 clears both errors at the edge. A new error event in the same cycle wins, so the flag is set.
- stack_flags_out is registered and holds its last popped value between restores.
- Width rules: depth saturates at 0 and at DEPTH and never wraps. Pointer arithmetic is modulo-free.

Optional Feature:
- Macro: CCR_SHADOW_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit computed from ccr_in at push.
  - On pop, parity is checked. On mismatch, a sticky parity_err output (1 bit, reset 0, cleared by err_clr) is set and stack_flags_out is forced to 0. load_from_stack still pulses.
- Undefined: no parity storage and no parity_err port. Behaviour otherwise identical.

Test Plan:
- Reset, then int_ack with ccr_in=4'b1010 -> depth=1, empty=0. rti_exec -> the next cycle has load_from_stack=1, stack_flags_out=4'b1010, depth=0.
- Nesting: push 4'h1, 4'h2, 4'h3, 4'h4 -> full=1. A 5th push with 4'hF -> overflow_err=1, depth stays 4. Four pops -> strobes carry 4,3,2,1 in that order.
- Pop on empty -> no strobe, underflow_err=1. err_clr -> 0. err_clr together with a new empty pop -> underflow_err stays 1.
- Depth=2 (4'h5, 4'h6), then int_ack and rti_exec together -> depth stays 2, no strobe. The following pop returns 4'h6.
- Two consecutive pops from depth=2 (4'h9, 4'hC) -> load_from_stack high for 2 cycles with 4'hC then 4'h9.
- rst_n asserted in the cycle after rti_exec -> load_from_stack=0 immediately, depth=0, errors=0. With CCR_SHADOW_PARITY_EN, a forced entry bit flip -> parity_err=1 and stack_flags_out=0.

Source files
------------

// File: rtl/ccr_shadow_stack_if.sv
// Interface bundling the condition-code shadow stack's control and status
// signals. The stack itself uses the slave modport; the CPU side (or a
// bench) uses the master modport.
//
// Handshake: int_ack, rti_exec and err_clr are single-cycle strobes that are
// sampled on the rising clk edge. They have no ready signal; every request is
// accepted or flagged as an error in the same cycle.
// load_from_stack is a one-cycle valid, and stack_flags_out is meaningful
// while it is high. The consumer (the CCR) is always ready.
//
// fsm_state reports the restore FSM state: 0 means IDLE, 1 means RESTORE.
// parity_err is present only when CCR_SHADOW_PARITY_EN is defined.
interface ccr_shadow_stack_if #(
  parameter int DEPTH  = 4,
  parameter int FLAG_W = 4
);
  localparam int DW = $clog2(DEPTH) + 1;

  logic [FLAG_W-1:0] ccr_in;
  logic              int_ack;
  logic              rti_exec;
  logic              err_clr;
  logic              load_from_stack;
  logic [FLAG_W-1:0] stack_flags_out;
  logic [DW-1:0]     depth;
  logic              full;
  logic              empty;
  logic              overflow_err;
  logic              underflow_err;
  logic              fsm_state;
`ifdef CCR_SHADOW_PARITY_EN
  logic              parity_err;
`endif

  modport slave (
    input  ccr_in, int_ack, rti_exec, err_clr,
    output load_from_stack, stack_flags_out, depth, full, empty,
           overflow_err, underflow_err, fsm_state
`ifdef CCR_SHADOW_PARITY_EN
    , output parity_err
`endif
  );

  modport master (
    output ccr_in, int_ack, rti_exec, err_clr,
    input  load_from_stack, stack_flags_out, depth, full, empty,
           overflow_err, underflow_err, fsm_state
`ifdef CCR_SHADOW_PARITY_EN
    , input parity_err
`endif
  );
endinterface

// File: rtl/ccr_shadow_stack.sv
// Shadow stack for the condition-code flags {V,C,N,Z}.
// - An interrupt entry (int_ack) pushes ccr_in.
// - An RTI (rti_exec) pops the top entry and pulses load_from_stack one cycle
//   later, with the restored flags on stack_flags_out.
// - When int_ack and rti_exec arrive together (a tail-chain), the stack and
//   depth are left untouched.
// Optional feature: define CCR_SHADOW_PARITY_EN to store an even-parity bit
// with each entry. A pop whose entry fails the parity check sets parity_err
// and restores zero flags.
module ccr_shadow_stack #(
  parameter int DEPTH  = 4,
  parameter int FLAG_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  ccr_shadow_stack_if.slave bus
);
  localparam int DW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);
`ifdef CCR_SHADOW_PARITY_EN
  localparam int ENTRY_W = FLAG_W + 1;
`else
  localparam int ENTRY_W = FLAG_W;
`endif
  localparam logic [DW-1:0] DEPTH_V = DW'(DEPTH);
  localparam logic [DW-1:0] DW_ONE  = DW'(1);
  localparam logic [AW-1:0] AW_ONE  = AW'(1);

  typedef enum logic {IDLE = 1'b0, RESTORE = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [DW-1:0]      depth_q, depth_d;
  logic [FLAG_W-1:0]  flags_q, flags_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic               full, empty;
  logic               push_req, pop_req, tail_req;
  logic               do_push, do_pop;
  logic [AW-1:0]      wr_idx, rd_idx;
  logic [ENTRY_W-1:0] wr_entry, rd_entry;
`ifdef CCR_SHADOW_PARITY_EN
  logic               par_q, par_d;
  logic               par_bad;
`endif

  assign full     = (depth_q == DEPTH_V);
  assign empty    = (depth_q == '0);
  // A simultaneous push and pop is a tail-chain. It moves no data.
  assign push_req = bus.int_ack & ~bus.rti_exec;
  assign pop_req  = bus.rti_exec & ~bus.int_ack;
  assign tail_req = bus.int_ack & bus.rti_exec;
  assign do_push  = push_req & ~full;
  assign do_pop   = pop_req & ~empty;
  // When full, only the low bits are zero, so subtracting one wraps to DEPTH-1.
  assign wr_idx   = depth_q[AW-1:0];
  assign rd_idx   = depth_q[AW-1:0] - AW_ONE;
  assign rd_entry = mem_q[rd_idx];
`ifdef CCR_SHADOW_PARITY_EN
  assign wr_entry = {^bus.ccr_in, bus.ccr_in};
  assign par_bad  = ^rd_entry;
`else
  assign wr_entry = bus.ccr_in;
`endif

  // Next-state logic: depth, restored flags, sticky errors and restore FSM.
  always_comb begin
    state_d = IDLE;
    depth_d = depth_q;
    flags_d = flags_q;
    ovf_d   = bus.err_clr ? 1'b0 : ovf_q;
    unf_d   = bus.err_clr ? 1'b0 : unf_q;
`ifdef CCR_SHADOW_PARITY_EN
    par_d   = bus.err_clr ? 1'b0 : par_q;
`endif
    if (do_push) begin
      depth_d = depth_q + DW_ONE;
    end
    if (push_req && full) begin
      ovf_d = 1'b1;
    end
    if ((pop_req || tail_req) && empty) begin
      unf_d = 1'b1;
    end
    if (do_pop) begin
      depth_d = depth_q - DW_ONE;
      state_d = RESTORE;
`ifdef CCR_SHADOW_PARITY_EN
      if (par_bad) begin
        flags_d = '0;
        par_d   = 1'b1;
      end else begin
        flags_d = rd_entry[FLAG_W-1:0];
      end
`else
      flags_d = rd_entry;
`endif
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      depth_q <= '0;
      flags_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
`ifdef CCR_SHADOW_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      flags_q <= flags_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
`ifdef CCR_SHADOW_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Entry storage. It is not reset because its contents are gated by depth.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_idx] <= wr_entry;
    end
  end

  assign bus.load_from_stack = (state_q == RESTORE);
  assign bus.stack_flags_out = flags_q;
  assign bus.depth           = depth_q;
  assign bus.full            = full;
  assign bus.empty           = empty;
  assign bus.overflow_err    = ovf_q;
  assign bus.underflow_err   = unf_q;
  assign bus.fsm_state       = state_q;
`ifdef CCR_SHADOW_PARITY_EN
  assign bus.parity_err      = par_q;
`endif
endmodule
